// File: rtl/pcie_rx_merge.sv
// Two-lane receive merger: two 4-deep lane FIFOs arbitrated into an 8-deep output FIFO.
// Define PCIE_MERGE_RR_EN for round-robin arbitration; the default is fixed lane-0 priority.
module pcie_rx_merge (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       init,
  input  logic [1:0] umbral_L,
  input  logic [5:0] data_in0,
  input  logic       push0,
  input  logic [5:0] data_in1,
  input  logic       push1,
  input  logic       pop,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic       pausa0,
  output logic       pausa1,
  output logic       active_out,
  output logic       idle_out,
  output logic       error_out
);

  typedef enum logic [2:0] {StReset, StInit, StIdle, StActive, StError} state_e;

  state_e     state_q, state_d;
  logic [1:0] umbral_q;
  logic [5:0] lane_mem_q [2][4];
  logic [1:0] lane_wp_q  [2];
  logic [1:0] lane_rp_q  [2];
  logic [2:0] lane_cnt_q [2];
  logic [5:0] out_mem_q  [8];
  logic [2:0] out_wp_q, out_rp_q;
  logic [3:0] out_cnt_q;
`ifdef PCIE_MERGE_RR_EN
  logic       prio_q;
`endif

  logic       run, do_pop, underflow, can_move, do_move, sel, any_ne, flush;
  logic [1:0] push, lane_ne, overflow, accept, lane_move, thr;
  logic [5:0] din [2];
  logic [2:0] pause_lvl;

  always_comb begin
    push    = {push1, push0};
    din[0]  = data_in0;
    din[1]  = data_in1;
    run     = (state_q == StIdle) || (state_q == StActive);
    lane_ne = 2'b00;
    overflow = 2'b00;
    accept  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      lane_ne[i]  = lane_cnt_q[i] != 3'd0;
      // A full lane rejects the push even if it is being drained this cycle.
      overflow[i] = run && push[i] && (lane_cnt_q[i] == 3'd4);
      accept[i]   = run && push[i] && (lane_cnt_q[i] != 3'd4);
    end
    do_pop    = run && pop && (out_cnt_q != 4'd0);
    underflow = run && pop && (out_cnt_q == 4'd0);
    can_move  = run && ((out_cnt_q != 4'd8) || do_pop);
`ifdef PCIE_MERGE_RR_EN
    sel = lane_ne[prio_q] ? prio_q : ~prio_q;
`else
    sel = ~lane_ne[0];
`endif
    do_move   = can_move && (|lane_ne);
    lane_move = do_move ? (sel ? 2'b10 : 2'b01) : 2'b00;
    any_ne    = (|lane_ne) || (out_cnt_q != 4'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StInit;
      StInit:   state_d = StIdle;
      StIdle: begin
        if ((|overflow) || underflow) state_d = StError;
        else if (any_ne)              state_d = StActive;
      end
      StActive: begin
        if ((|overflow) || underflow) state_d = StError;
        else if (!any_ne)             state_d = StIdle;
      end
      StError:  state_d = StError;
      default:  state_d = StReset;
    endcase
    if (init) state_d = StInit;
    flush = (state_d == StInit);
  end

  always_comb begin
    thr        = (umbral_q == 2'd0) ? 2'd1 : umbral_q;
    pause_lvl  = 3'd4 - {1'b0, thr};
    error_out  = state_q == StError;
    active_out = state_q == StActive;
    idle_out   = state_q == StIdle;
    pausa0     = error_out || (lane_cnt_q[0] >= pause_lvl);
    pausa1     = error_out || (lane_cnt_q[1] >= pause_lvl);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q   <= StReset;
      umbral_q  <= 2'b01;
      data_out  <= 6'd0;
      valid_out <= 1'b0;
      out_wp_q  <= 3'd0;
      out_rp_q  <= 3'd0;
      out_cnt_q <= 4'd0;
      for (int i = 0; i < 2; i++) begin
        lane_wp_q[i]  <= 2'd0;
        lane_rp_q[i]  <= 2'd0;
        lane_cnt_q[i] <= 3'd0;
      end
    end else begin
      state_q   <= state_d;
      if (state_q == StInit) umbral_q <= umbral_L;
      valid_out <= do_pop;
      if (do_pop) data_out <= out_mem_q[out_rp_q];
      if (flush) begin
        out_wp_q  <= 3'd0;
        out_rp_q  <= 3'd0;
        out_cnt_q <= 4'd0;
        for (int i = 0; i < 2; i++) begin
          lane_wp_q[i]  <= 2'd0;
          lane_rp_q[i]  <= 2'd0;
          lane_cnt_q[i] <= 3'd0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (accept[i])    lane_wp_q[i] <= lane_wp_q[i] + 2'd1;
          if (lane_move[i]) lane_rp_q[i] <= lane_rp_q[i] + 2'd1;
          lane_cnt_q[i] <= lane_cnt_q[i] + {2'b00, accept[i]} - {2'b00, lane_move[i]};
        end
        if (do_move) out_wp_q <= out_wp_q + 3'd1;
        if (do_pop)  out_rp_q <= out_rp_q + 3'd1;
        out_cnt_q <= out_cnt_q + {3'b000, do_move} - {3'b000, do_pop};
      end
    end
  end

  // Storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) lane_mem_q[i][lane_wp_q[i]] <= din[i];
    end
    if (do_move) out_mem_q[out_wp_q] <= lane_mem_q[sel][lane_rp_q[sel]];
  end

`ifdef PCIE_MERGE_RR_EN
  always_ff @(posedge clk) begin
    if (!reset_L)     prio_q <= 1'b0;
    else if (do_move) prio_q <= ~sel;
  end
`endif

endmodule

// File: tb/tb_pcie_rx_merge.sv
// Bench for pcie_rx_merge: directed scenarios plus random traffic against a queue-based model.
module tb_pcie_rx_merge;

`ifdef PCIE_MERGE_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif
  localparam int SReset = 0, SInit = 1, SIdle = 2, SActive = 3, SError = 4;

  logic       clk = 1'b0;
  logic       reset_L, init, push0, push1, pop;
  logic [1:0] umbral_L;
  logic [5:0] data_in0, data_in1;
  logic [5:0] data_out;
  logic       valid_out, pausa0, pausa1, active_out, idle_out, error_out;

  always #5 clk = ~clk;

  pcie_rx_merge dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .umbral_L   (umbral_L),
    .data_in0   (data_in0),
    .push0      (push0),
    .data_in1   (data_in1),
    .push1      (push1),
    .pop        (pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .pausa0     (pausa0),
    .pausa1     (pausa1),
    .active_out (active_out),
    .idle_out   (idle_out),
    .error_out  (error_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         m_st = SReset;
  logic [5:0] q0[$], q1[$], qo[$];
  logic [1:0] m_um = 2'b01;
  bit         m_prio = 1'b0;
  logic [5:0] m_dout = 6'd0;
  bit         m_vld = 1'b0;

  function automatic void model_step();
    bit run, ovf0, ovf1, popok, udf, can, sel, err;
    int n0, n1, no;
    if (!reset_L) begin
      q0.delete(); q1.delete(); qo.delete();
      m_st = SReset; m_um = 2'b01; m_prio = 1'b0; m_dout = 6'd0; m_vld = 1'b0;
      return;
    end
    n0 = q0.size(); n1 = q1.size(); no = qo.size();
    run   = (m_st == SIdle) || (m_st == SActive);
    ovf0  = run && push0 && (n0 == 4);
    ovf1  = run && push1 && (n1 == 4);
    popok = run && pop && (no > 0);
    udf   = run && pop && (no == 0);
    err   = ovf0 || ovf1 || udf;
    m_vld = popok;
    if (popok) m_dout = qo.pop_front();
    can = run && ((no < 8) || popok);
    if (RrEn) sel = ((m_prio ? n1 : n0) > 0) ? m_prio : !m_prio;
    else      sel = (n0 == 0);
    if (can && (n0 > 0 || n1 > 0)) begin
      if (sel) qo.push_back(q1.pop_front());
      else     qo.push_back(q0.pop_front());
      m_prio = !sel;
    end
    if (run && push0 && !ovf0) q0.push_back(data_in0);
    if (run && push1 && !ovf1) q1.push_back(data_in1);
    if (m_st == SInit) m_um = umbral_L;
    if (init) m_st = SInit;
    else begin
      case (m_st)
        SReset:  m_st = SInit;
        SInit:   m_st = SIdle;
        SIdle:   m_st = err ? SError : ((n0 + n1 + no) > 0 ? SActive : SIdle);
        SActive: m_st = err ? SError : ((n0 + n1 + no) == 0 ? SIdle : SActive);
        default: m_st = m_st;
      endcase
    end
    if (m_st == SInit) begin
      q0.delete(); q1.delete(); qo.delete();
    end
  endfunction

  task automatic compare_all();
    int thr;
    thr = (m_um == 2'd0) ? 1 : int'(m_um);
    check("data_out", data_out, m_dout);
    check("valid_out", valid_out, m_vld);
    check("pausa0", pausa0, (m_st == SError) || (q0.size() >= 4 - thr));
    check("pausa1", pausa1, (m_st == SError) || (q1.size() >= 4 - thr));
    check("active_out", active_out, m_st == SActive);
    check("idle_out", idle_out, m_st == SIdle);
    check("error_out", error_out, m_st == SError);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    push0 = 1'b0; push1 = 1'b0; pop = 1'b0;
  endtask

  task automatic reset_and_init(input logic [1:0] um);
    quiet();
    reset_L = 1'b0; init = 1'b0;
    step(); step();
    reset_L = 1'b1; init = 1'b1; umbral_L = um;
    step(); step(); step();
    init = 1'b0;
    step();
  endtask

  logic [5:0] exp_order [8];

  initial begin
    reset_L = 1'b0; init = 1'b0; umbral_L = 2'd0;
    data_in0 = 6'd0; data_in1 = 6'd0;
    quiet();

    // Reset values, then configure and land in IDLE
    step(); step();
    check("rst_data_out", data_out, 6'd0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_status", {pausa0, pausa1, active_out, idle_out, error_out}, 5'b00000);
    reset_L = 1'b1; init = 1'b1; umbral_L = 2'd2;
    step(); step(); step();
    init = 1'b0;
    step();
    check("cfg_idle", idle_out, 1'b1);
    check("cfg_others", {active_out, error_out, pausa0, pausa1}, 4'b0000);

    // Minimum latency path
    push0 = 1'b1; data_in0 = 6'h15;
    step();
    push0 = 1'b0;
    step();
    pop = 1'b1;
    step();
    check("lat_data", data_out, 6'h15);
    check("lat_valid", valid_out, 1'b1);
    pop = 1'b0;
    step(); step();
    check("lat_back_idle", idle_out, 1'b1);

    // Both lanes pushing together: arbitration order
    reset_and_init(2'd2);
    for (int i = 0; i < 4; i++) begin
      push0 = 1'b1; data_in0 = 6'(8'h01 + i);
      push1 = 1'b1; data_in1 = 6'(8'h11 + i);
      step();
    end
    quiet();
    for (int i = 0; i < 6; i++) step();
    for (int k = 0; k < 8; k++) begin
      if (RrEn) exp_order[k] = (k % 2 == 0) ? 6'(8'h01 + k / 2) : 6'(8'h11 + k / 2);
      else      exp_order[k] = (k < 4) ? 6'(8'h01 + k) : 6'(8'h11 + k - 4);
    end
    for (int k = 0; k < 8; k++) begin
      pop = 1'b1;
      step();
      check($sformatf("order%0d", k), {valid_out, data_out}, {1'b1, exp_order[k]});
    end
    pop = 1'b0;
    step();

    // Backpressure with a full output FIFO
    reset_and_init(2'd2);
    for (int i = 0; i < 8; i++) begin
      push0 = 1'b1; data_in0 = 6'(8'h20 + i);
      step();
    end
    quiet();
    step(); step(); step();
    push1 = 1'b1; data_in1 = 6'h31;
    step();
    check("pausa1_occ1", pausa1, 1'b0);
    data_in1 = 6'h32;
    step();
    check("pausa1_occ2", pausa1, 1'b1);
    push1 = 1'b0;

    // Overflow of lane 0, then recovery through INIT
    for (int i = 0; i < 4; i++) begin
      push0 = 1'b1; data_in0 = 6'(8'h01 + i);
      step();
    end
    check("pausa0_full", pausa0, 1'b1);
    data_in0 = 6'h3f;
    step();
    push0 = 1'b0;
    check("ovf_error", error_out, 1'b1);
    check("ovf_pausa", {pausa0, pausa1}, 2'b11);
    init = 1'b1;
    step();
    check("init_status", {active_out, idle_out, error_out}, 3'b000);
    check("init_flushed", {pausa0, pausa1}, 2'b00);
    init = 1'b0;
    step(); step();
    check("init_idle_empty", idle_out, 1'b1);

    // Underflow
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("udf_error", error_out, 1'b1);
    check("udf_valid", valid_out, 1'b0);

    // Random traffic against the model
    reset_and_init(2'($urandom_range(0, 3)));
    for (int c = 0; c < 1500; c++) begin
      reset_L  = ($urandom_range(0, 299) != 0);
      init     = ($urandom_range(0, 59) == 0) || (m_st == SError && $urandom_range(0, 3) == 0);
      umbral_L = 2'($urandom_range(0, 3));
      data_in0 = 6'($urandom);
      data_in1 = 6'($urandom);
      push0    = (q0.size() < 4) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 4);
      push1    = (q1.size() < 4) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 4);
      pop      = (qo.size() > 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 3);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
